fetch_redirect_ctrl: RTL

Fetch-stage PC sequencer for the forwarding pipeline. It owns the fetch PC register and advances it each cycle with the static predictor's next-PC guess. It records every predicted control instruction in a small in-flight queue and checks each one against the EX-stage resolution. On a mispredict it reloads the PC with the correct target and pulses a pipeline flush.

---
 rtl/fetch_redirect_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: advances the fetch PC with the predictor's guess, tracks in-flight
// predicted control instructions and redirects/flushes when EX resolution disagrees.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    output logic [31:0] pc,
    input  logic [31:0] pc_predict,
    input  logic        is_ctrl,
    output logic        fetch_valid,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        flush,
    output logic        queue_full,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt,
    output logic        protocol_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {BOOT, RUN, FULL} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] head_q, tail_q;
    logic [31:0]   qpc_q   [DEPTH];
    logic [31:0]   qpred_q [DEPTH];
    logic [15:0]   bcnt_q, mcnt_q;
    logic          perr_q;

    logic          pop, push, mispredict;
    logic [31:0]   hpc, hpred, actual;

    always_comb begin
        hpc         = qpc_q[head_q];
        hpred       = qpred_q[head_q];
        queue_full  = (cnt_q == (AW+1)'(DEPTH));
        pop         = res_valid && (cnt_q != '0);
        actual      = res_taken ? res_target : hpc + 32'd4;
        mispredict  = pop && (actual != hpred);
        fetch_valid = (state_q == RUN) && !stall_if && !(queue_full && is_ctrl && !pop);
        push        = fetch_valid && is_ctrl && !mispredict;
        flush       = mispredict;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN:  if (push && !pop && cnt_q == (AW+1)'(DEPTH - 1)) state_d = FULL;
            FULL: if (pop) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        // A redirect invalidates everything younger than the resolved branch.
        if (mispredict) begin
            state_d = RUN;
            cnt_d   = '0;
            pc_d    = actual;
        end else if (fetch_valid) begin
            pc_d = pc_predict;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            if (mispredict) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (pop)  head_q <= head_q + 1'b1;
                if (push) tail_q <= tail_q + 1'b1;
            end
            if (pop && bcnt_q != 16'hFFFF)        bcnt_q <= bcnt_q + 16'd1;
            if (mispredict && mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
            if (res_valid && cnt_q == '0)         perr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[tail_q]   <= pc_q;
            qpred_q[tail_q] <= pc_predict;
        end
    end

    assign pc             = pc_q;
    assign branch_cnt     = bcnt_q;
    assign mispredict_cnt = mcnt_q;
    assign protocol_err   = perr_q;

endmodule
